// File: rtl/cmd_exec_pkg.sv
// Shared types and defaults for the command executor: opcodes, FSM states,
// speed constants and the heading expansion helper.
package cmd_exec_pkg;

  localparam logic [9:0] DEF_MAX_SPD = 10'h300;
  localparam logic [9:0] DEF_SPD_INC = 10'h004;

  typedef enum logic [3:0] {
    OP_CAL     = 4'h0,
    OP_MOVE    = 4'h2,
    OP_MOVE_FF = 4'h3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_HEAD,
    ST_RAMP,
    ST_DECEL,
    ST_DONE
  } state_e;

  // A zero heading means "north" and is sent as all zeros, not {0,F}.
  function automatic logic [11:0] heading_map(input logic [7:0] hdg);
    return (hdg != 8'h00) ? {hdg, 4'hF} : 12'h000;
  endfunction

endpackage

// File: rtl/cmd_exec_spd.sv
// Saturating forward-speed register: ramps up by SPD_INC toward MAX_SPD,
// ramps down by 2*SPD_INC toward zero, clr forces zero (priority clr > inc > dec).
module cmd_exec_spd
  import cmd_exec_pkg::*;
#(
  parameter logic [9:0] SPD_INC = DEF_SPD_INC,
  parameter logic [9:0] MAX_SPD = DEF_MAX_SPD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [9:0] spd_o
);

  logic [9:0]  spd_q, spd_d;
  logic [10:0] up_sum;
  logic [10:0] dn_diff;

  // One extra bit on each side so overflow and borrow are visible.
  assign up_sum  = {1'b0, spd_q} + {1'b0, SPD_INC};
  assign dn_diff = {1'b0, spd_q} - {SPD_INC, 1'b0};

  // NOTE: combinational next-state logic assigns a default first so no path leaves spd_d unassigned (no latch).
  always_comb begin
    spd_d = spd_q;
    if (clr_i) begin
      spd_d = '0;
    end else if (inc_i) begin
      spd_d = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
    end else if (dec_i) begin
      spd_d = dn_diff[10] ? 10'h000 : dn_diff[9:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spd_q <= '0;
    else        spd_q <= spd_d;
  end

  assign spd_o = spd_q;

endmodule

// File: rtl/cmd_exec.sv
// Command executor: accepts calibrate/move commands, sequences heading,
// speed ramp, line counting and deceleration. Define FANFARE_EN to enable fanfare_go.
module cmd_exec
  import cmd_exec_pkg::*;
#(
  parameter logic [9:0] SPD_INC = DEF_SPD_INC,
  parameter logic [9:0] MAX_SPD = DEF_MAX_SPD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  input  logic        cntrIR,
  input  logic        heading_rdy,
  input  logic        cal_done,
  output logic        cal_go,
  output logic [11:0] desired_heading,
  output logic [9:0]  frwrd_spd,
  output logic        moving,
  output logic        fanfare_go
);

  state_e      state_q, state_d;
  logic [3:0]  sq_q;
  logic [4:0]  cnt_q;
  logic [11:0] hdg_q;
  logic        ir_q;
  logic        cal_go_q;
  logic        capture;
  logic        is_move;
  logic        spd_clr, spd_inc, spd_dec;
  logic        ir_rise;

  assign is_move = (cmd[15:12] == OP_MOVE) || (cmd[15:12] == OP_MOVE_FF);
  assign ir_rise = cntrIR & ~ir_q;

  always_comb begin
    state_d     = state_q;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    capture     = 1'b0;
    spd_clr     = 1'b0;
    spd_inc     = 1'b0;
    spd_dec     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        spd_clr = 1'b1;
        if (cmd_rdy) begin
          capture     = 1'b1;
          clr_cmd_rdy = 1'b1;
          if (cmd[15:12] == OP_CAL) state_d = ST_CAL;
          else if (is_move)         state_d = ST_HEAD;
          else                      state_d = ST_DONE;
        end
      end
      ST_CAL: begin
        spd_clr = 1'b1;
        if (cal_done) state_d = ST_DONE;
      end
      ST_HEAD: begin
        spd_clr = 1'b1;
        if (heading_rdy) state_d = (sq_q == 4'h0) ? ST_DONE : ST_RAMP;
      end
      ST_RAMP: begin
        spd_inc = 1'b1;
        if (cnt_q == {sq_q, 1'b0}) state_d = ST_DECEL;
      end
      ST_DECEL: begin
        spd_dec = 1'b1;
        if (frwrd_spd == 10'h000) state_d = ST_DONE;
      end
      ST_DONE: begin
        send_resp = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sq_q     <= '0;
      cnt_q    <= '0;
      hdg_q    <= '0;
      ir_q     <= 1'b0;
      cal_go_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= cntrIR;
      cal_go_q <= capture && (cmd[15:12] == OP_CAL);
      if (capture) begin
        sq_q  <= cmd[3:0];
        cnt_q <= '0;
        // Heading only changes on a move; calibrate and unknown keep the last one.
        if (is_move) hdg_q <= heading_map(cmd[11:4]);
      end else if (state_q == ST_RAMP && ir_rise) begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

`ifdef FANFARE_EN
  logic ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ff_q <= 1'b0;
    else if (capture) ff_q <= (cmd[15:12] == OP_MOVE_FF);
  end

  assign fanfare_go = (state_q == ST_DONE) && ff_q;
`else
  assign fanfare_go = 1'b0;
`endif

  cmd_exec_spd #(
    .SPD_INC (SPD_INC),
    .MAX_SPD (MAX_SPD)
  ) u_spd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (spd_clr),
    .inc_i (spd_inc),
    .dec_i (spd_dec),
    .spd_o (frwrd_spd)
  );

  assign desired_heading = hdg_q;
  assign cal_go          = cal_go_q;
  assign moving          = (state_q == ST_HEAD) || (state_q == ST_RAMP) || (state_q == ST_DECEL);

endmodule

// File: doc/cmd_exec.md
CMD_EXEC -- requirements
Module: cmd_exec

Interface
REQ-001 Parameter SPD_INC, default 10'h004, forward-speed increment per clock while ramping up.
REQ-002 Parameter MAX_SPD, default 10'h300, forward-speed saturation ceiling.
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port cmd  input  16  command word: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-006 Port cmd_rdy  input  1  command valid, held until cleared.
REQ-007 Port clr_cmd_rdy  output  1  one-cycle pulse; command consumed.
REQ-008 Port send_resp  output  1  one-cycle pulse; command finished.
REQ-009 Port cntrIR  input  1  line-crossing sensor, high while over a line.
REQ-010 Port heading_rdy  input  1  heading error within tolerance.
REQ-011 Port cal_done  input  1  calibration complete.
REQ-012 Port cal_go  output  1  one-cycle calibration start pulse.
REQ-013 Port desired_heading  output  12  target heading to steering loop.
REQ-014 Port frwrd_spd  output  10  forward speed command.
REQ-015 Port moving  output  1  high in HEAD, RAMP and DECEL.
REQ-016 Port fanfare_go  output  1  one-cycle pulse after an opcode-0x3 move.

Function
REQ-017 Opcodes SHALL be: 4'h0 calibrate, 4'h2 move, 4'h3 move-with-fanfare; all others are unknown.
REQ-018 States SHALL be IDLE, CAL, HEAD, RAMP, DECEL, DONE.
REQ-019 In IDLE with cmd_rdy=1, the block SHALL capture cmd, pulse clr_cmd_rdy in that same cycle, and branch on opcode in the next state.
REQ-020 Calibrate SHALL pulse cal_go in the cycle of entry to CAL, wait in CAL for cal_done=1, then go to DONE.
REQ-021 Move SHALL set desired_heading = {heading,4'hF} when heading != 0, else 12'h000, registered on capture and held until the next move capture.
REQ-022 In HEAD, frwrd_spd SHALL be 0; on heading_rdy=1, go to RAMP, or to DONE if squares=0.
REQ-023 In RAMP, frwrd_spd SHALL increase by SPD_INC per clock, saturating at MAX_SPD.
REQ-024 Crossing counter SHALL clear on capture and increment on each rising edge of cntrIR (one-flop edge detect) in RAMP.
REQ-025 When count equals 2*squares (5-bit compare), the block SHALL enter DECEL the next cycle.
REQ-026 In DECEL, frwrd_spd SHALL decrease by 2*SPD_INC per clock, saturating at 0; at 0, go to DONE.
REQ-027 DONE SHALL last one cycle, pulse send_resp, pulse fanfare_go if opcode was 4'h3, then return to IDLE.
REQ-028 An unknown opcode SHALL pulse clr_cmd_rdy, go directly to DONE, and produce no motion or cal_go.
REQ-029 cmd_rdy SHALL be ignored in every state except IDLE; clr_cmd_rdy and send_resp SHALL never be high in the same cycle.

Reset
REQ-030 On rst_n=0, the block SHALL enter IDLE, with frwrd_spd=0, desired_heading=0, counter=0, and every pulse output and moving at 0; this holds mid-move.

Configuration
REQ-031 With FANFARE_EN defined, opcode 4'h3 SHALL behave per REQ-027.
REQ-032 Without FANFARE_EN, opcode 4'h3 SHALL behave as 4'h2 and fanfare_go SHALL be tied to 0.

Structure
REQ-033 Package cmd_exec_pkg SHALL hold the opcode enum, the state enum and the default MAX_SPD/SPD_INC constants.
REQ-034 Sub-module cmd_exec_spd SHALL implement the saturating up/down speed register (inc, dec, clr inputs).

Verification
REQ-035 cmd=16'h2002, heading_rdy=1, 4 cntrIR pulses -> clr_cmd_rdy same cycle, desired_heading=12'h000, frwrd_spd ramps to 10'h300, DECEL after 4th edge, one send_resp.
REQ-036 cmd=16'h37F1 with FANFARE_EN -> desired_heading=12'h7FF, send_resp and fanfare_go in the same cycle after 2 crossings; without FANFARE_EN, fanfare_go stays 0.
REQ-037 cmd=16'h0000 -> cal_go one cycle, cal_done after 100 cycles -> send_resp one cycle later, frwrd_spd stays 0.
REQ-038 cmd=16'h2000 and cmd=16'h9000 -> send_resp with frwrd_spd never nonzero.
REQ-039 rst_n low mid-RAMP -> frwrd_spd=0 and state IDLE immediately; a new cmd after release is accepted normally.
